// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache/memory arbiter: bus widths, requester identities
// and small helpers that classify a requester.
package cache_mem_arbiter_pkg;

  typedef logic [31:0]  bus32_t;
  typedef logic [255:0] bus256_t;

  typedef enum logic [2:0] {
    OWN_IC    = 3'd0,
    OWN_DC_RD = 3'd1,
    OWN_DC_WR = 3'd2,
    OWN_UC_RD = 3'd3,
    OWN_UC_WR = 3'd4
  } arb_owner_e;

  localparam int unsigned NumOwners = 5;

  function automatic arb_owner_e grant_owner(input logic [NumOwners-1:0] grant);
    arb_owner_e owner;
    owner = OWN_IC;
    for (int i = 0; i < NumOwners; i++) begin
      if (grant[i]) owner = arb_owner_e'(3'(i));
    end
    return owner;
  endfunction

  function automatic logic owner_is_read(input arb_owner_e owner);
    return (owner == OWN_IC) || (owner == OWN_DC_RD) || (owner == OWN_UC_RD);
  endfunction

  function automatic logic owner_is_line(input arb_owner_e owner);
    return (owner == OWN_IC) || (owner == OWN_DC_RD) || (owner == OWN_DC_WR);
  endfunction

endpackage

// File: rtl/cache_arb_grant.sv
// Combinational grant pick: fixed priority for writes and uncached traffic,
// round-robin (or dcache-first) between the two refill requesters.
module cache_arb_grant
  import cache_mem_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic [NumOwners-1:0] req,
  input  logic                 rr_dc,
  output logic [NumOwners-1:0] grant
);

  // Writeback wins so a victim reaches memory before its set is refilled.
  always_comb begin
    grant = '0;
    if (req[OWN_DC_WR]) begin
      grant[OWN_DC_WR] = 1'b1;
    end else if (req[OWN_UC_WR]) begin
      grant[OWN_UC_WR] = 1'b1;
    end else if (req[OWN_UC_RD]) begin
      grant[OWN_UC_RD] = 1'b1;
    end else if (req[OWN_IC] && req[OWN_DC_RD]) begin
      if (RR_EN && !rr_dc) grant[OWN_IC] = 1'b1;
      else                 grant[OWN_DC_RD] = 1'b1;
    end else if (req[OWN_IC]) begin
      grant[OWN_IC] = 1'b1;
    end else if (req[OWN_DC_RD]) begin
      grant[OWN_DC_RD] = 1'b1;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port among icache/dcache refills, dcache writeback and
// uncached reads/writes; a single transaction is outstanding at a time.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned RR_EN  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_rd_req,
  input  logic [ADDR_W-1:0] ic_rd_addr,
  output logic              ic_rd_rdy,
  output logic              ic_ret_valid,
  output logic [LINE_W-1:0] ic_ret_data,
  input  logic              dc_rd_req,
  input  logic [ADDR_W-1:0] dc_rd_addr,
  output logic              dc_rd_rdy,
  output logic              dc_ret_valid,
  output logic [LINE_W-1:0] dc_ret_data,
  input  logic              dc_wr_req,
  input  logic [ADDR_W-1:0] dc_wr_addr,
  input  logic [LINE_W-1:0] dc_wr_data,
  output logic              dc_wr_rdy,
  output logic              dc_bvalid,
  input  logic              uc_ren,
  input  logic [31:0]       uc_araddr,
  output logic              uc_rrdy,
  output logic              uc_rvalid,
  output logic [31:0]       uc_rdata,
  input  logic              uc_wen,
  input  logic [31:0]       uc_awaddr,
  input  logic [31:0]       uc_wdata,
  input  logic [3:0]        uc_wstrb,
  output logic              uc_wrdy,
  output logic              uc_bvalid,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              mem_rd_line,
  input  logic              mem_rd_rdy,
  input  logic              mem_ret_valid,
  input  logic [LINE_W-1:0] mem_ret_data,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic              mem_wr_line,
  output logic [LINE_W-1:0] mem_wr_data,
  output logic [3:0]        mem_wr_strb,
  input  logic              mem_wr_rdy,
  input  logic              mem_bvalid
);

  typedef enum logic [2:0] {
    StIdle,
    StRdIssue,
    StRdWait,
    StWrIssue,
    StWrWait,
    StResp
  } state_e;

  localparam logic [ADDR_W-1:0] LineMask = ADDR_W'(LINE_W / 8 - 1);

  state_e              state_q, state_d;
  arb_owner_e          owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic [3:0]          strb_q, strb_d;
  logic                line_q, line_d;
  logic                rr_dc_q, rr_dc_d;

  logic [NumOwners-1:0] req_vec;
  logic [NumOwners-1:0] grant;
  logic                 idle_ok;
  logic                 accept;
  arb_owner_e           acc_owner;

  always_comb begin
    req_vec            = '0;
    req_vec[OWN_IC]    = ic_rd_req;
    req_vec[OWN_DC_RD] = dc_rd_req;
    req_vec[OWN_DC_WR] = dc_wr_req;
    req_vec[OWN_UC_RD] = uc_ren;
    req_vec[OWN_UC_WR] = uc_wen;
  end

  cache_arb_grant #(
    .RR_EN(RR_EN != 0)
  ) u_grant (
    .req  (req_vec),
    .rr_dc(rr_dc_q),
    .grant(grant)
  );

  assign idle_ok   = (state_q == StIdle) && !reset;
  assign accept    = idle_ok && (|grant);
  assign acc_owner = grant_owner(grant);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = owner_is_read(acc_owner) ? StRdIssue : StWrIssue;
      StRdIssue: if (mem_rd_rdy) state_d = StRdWait;
      StRdWait:  if (mem_ret_valid) state_d = StResp;
      StWrIssue: if (mem_wr_rdy) state_d = StWrWait;
      StWrWait:  if (mem_bvalid) state_d = StResp;
      StResp:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    ic_rd_rdy    = idle_ok && grant[OWN_IC];
    dc_rd_rdy    = idle_ok && grant[OWN_DC_RD];
    dc_wr_rdy    = idle_ok && grant[OWN_DC_WR];
    uc_rrdy      = idle_ok && grant[OWN_UC_RD];
    uc_wrdy      = idle_ok && grant[OWN_UC_WR];

    mem_rd_req   = (state_q == StRdIssue);
    mem_rd_addr  = addr_q;
    mem_rd_line  = line_q;
    mem_wr_req   = (state_q == StWrIssue);
    mem_wr_addr  = addr_q;
    mem_wr_line  = line_q;
    mem_wr_data  = wdata_q;
    mem_wr_strb  = strb_q;

    ic_ret_valid = (state_q == StResp) && (owner_q == OWN_IC);
    dc_ret_valid = (state_q == StResp) && (owner_q == OWN_DC_RD);
    dc_bvalid    = (state_q == StResp) && (owner_q == OWN_DC_WR);
    uc_rvalid    = (state_q == StResp) && (owner_q == OWN_UC_RD);
    uc_bvalid    = (state_q == StResp) && (owner_q == OWN_UC_WR);
    ic_ret_data  = ic_ret_valid ? rdata_q : '0;
    dc_ret_data  = dc_ret_valid ? rdata_q : '0;
    uc_rdata     = uc_rvalid ? rdata_q[31:0] : '0;
  end

  // Request fields are captured on accept so the memory side sees them stable.
  always_comb begin
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    strb_d  = strb_q;
    line_d  = line_q;
    rr_dc_d = rr_dc_q;
    if (accept) begin
      owner_d = acc_owner;
      line_d  = owner_is_line(acc_owner);
      strb_d  = 4'hF;
      wdata_d = '0;
      unique case (acc_owner)
        OWN_IC:    addr_d = ic_rd_addr;
        OWN_DC_RD: addr_d = dc_rd_addr;
        OWN_DC_WR: begin
          addr_d  = dc_wr_addr;
          wdata_d = dc_wr_data;
        end
        OWN_UC_RD: addr_d = ADDR_W'(uc_araddr);
        OWN_UC_WR: begin
          addr_d  = ADDR_W'(uc_awaddr);
          wdata_d = LINE_W'(uc_wdata);
          strb_d  = uc_wstrb;
        end
        default:   addr_d = addr_q;
      endcase
      if (line_d) addr_d = addr_d & ~LineMask;
      if (RR_EN != 0) begin
        if (acc_owner == OWN_IC)         rr_dc_d = 1'b1;
        else if (acc_owner == OWN_DC_RD) rr_dc_d = 1'b0;
      end
    end
    if ((state_q == StRdWait) && mem_ret_valid) begin
      rdata_d = (owner_q == OWN_UC_RD) ? LINE_W'(mem_ret_data[31:0]) : mem_ret_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWN_IC;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      strb_q  <= '0;
      line_q  <= 1'b0;
      rr_dc_q <= 1'b0;
    end else begin
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      strb_q  <= strb_d;
      line_q  <= line_d;
      rr_dc_q <= rr_dc_d;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter; a second instance with RR_EN=0 runs in
// lockstep on the same inputs to show dcache-first refill priority.
module tb_cache_mem_arbiter;

  localparam logic [255:0] LineA = 256'h8888_8888_7777_7777_6666_6666_5555_5555_4444_4444_3333_3333_2222_2222_1111_1111;
  localparam logic [255:0] LineW = 256'hF0F0_0001_F0F0_0002_F0F0_0003_F0F0_0004_F0F0_0005_F0F0_0006_F0F0_0007_F0F0_0008;
  localparam logic [255:0] LineU = 256'hABCD_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_DEAD_BEEF;

  logic clk = 1'b0;
  logic reset;
  logic ic_rd_req, dc_rd_req, dc_wr_req, uc_ren, uc_wen;
  logic [31:0] ic_rd_addr, dc_rd_addr, dc_wr_addr, uc_araddr, uc_awaddr, uc_wdata;
  logic [255:0] dc_wr_data, mem_ret_data;
  logic [3:0] uc_wstrb;
  logic mem_rd_rdy, mem_ret_valid, mem_wr_rdy, mem_bvalid;

  logic ic_rd_rdy, ic_ret_valid, dc_rd_rdy, dc_ret_valid, dc_wr_rdy, dc_bvalid;
  logic [255:0] ic_ret_data, dc_ret_data, mem_wr_data;
  logic uc_rrdy, uc_rvalid, uc_wrdy, uc_bvalid;
  logic [31:0] uc_rdata, mem_rd_addr, mem_wr_addr;
  logic mem_rd_req, mem_rd_line, mem_wr_req, mem_wr_line;
  logic [3:0] mem_wr_strb;

  logic fp_ic_rd_rdy, fp_ic_ret_valid, fp_dc_rd_rdy, fp_dc_ret_valid, fp_dc_wr_rdy;
  logic fp_dc_bvalid, fp_uc_rrdy, fp_uc_rvalid, fp_uc_wrdy, fp_uc_bvalid;
  logic [255:0] fp_ic_ret_data, fp_dc_ret_data, fp_mem_wr_data;
  logic [31:0] fp_uc_rdata, fp_mem_rd_addr, fp_mem_wr_addr;
  logic fp_mem_rd_req, fp_mem_rd_line, fp_mem_wr_req, fp_mem_wr_line;
  logic [3:0] fp_mem_wr_strb;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(32), .LINE_W(256), .RR_EN(1)) u_dut (
    .clk(clk), .reset(reset),
    .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(ic_rd_rdy),
    .ic_ret_valid(ic_ret_valid), .ic_ret_data(ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(dc_rd_rdy),
    .dc_ret_valid(dc_ret_valid), .dc_ret_data(dc_ret_data),
    .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
    .dc_wr_rdy(dc_wr_rdy), .dc_bvalid(dc_bvalid),
    .uc_ren(uc_ren), .uc_araddr(uc_araddr), .uc_rrdy(uc_rrdy),
    .uc_rvalid(uc_rvalid), .uc_rdata(uc_rdata),
    .uc_wen(uc_wen), .uc_awaddr(uc_awaddr), .uc_wdata(uc_wdata), .uc_wstrb(uc_wstrb),
    .uc_wrdy(uc_wrdy), .uc_bvalid(uc_bvalid),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_line(mem_rd_line),
    .mem_rd_rdy(mem_rd_rdy), .mem_ret_valid(mem_ret_valid), .mem_ret_data(mem_ret_data),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_line(mem_wr_line),
    .mem_wr_data(mem_wr_data), .mem_wr_strb(mem_wr_strb),
    .mem_wr_rdy(mem_wr_rdy), .mem_bvalid(mem_bvalid)
  );

  cache_mem_arbiter #(.ADDR_W(32), .LINE_W(256), .RR_EN(0)) u_dut_fp (
    .clk(clk), .reset(reset),
    .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(fp_ic_rd_rdy),
    .ic_ret_valid(fp_ic_ret_valid), .ic_ret_data(fp_ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(fp_dc_rd_rdy),
    .dc_ret_valid(fp_dc_ret_valid), .dc_ret_data(fp_dc_ret_data),
    .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
    .dc_wr_rdy(fp_dc_wr_rdy), .dc_bvalid(fp_dc_bvalid),
    .uc_ren(uc_ren), .uc_araddr(uc_araddr), .uc_rrdy(fp_uc_rrdy),
    .uc_rvalid(fp_uc_rvalid), .uc_rdata(fp_uc_rdata),
    .uc_wen(uc_wen), .uc_awaddr(uc_awaddr), .uc_wdata(uc_wdata), .uc_wstrb(uc_wstrb),
    .uc_wrdy(fp_uc_wrdy), .uc_bvalid(fp_uc_bvalid),
    .mem_rd_req(fp_mem_rd_req), .mem_rd_addr(fp_mem_rd_addr),
    .mem_rd_line(fp_mem_rd_line), .mem_rd_rdy(mem_rd_rdy),
    .mem_ret_valid(mem_ret_valid), .mem_ret_data(mem_ret_data),
    .mem_wr_req(fp_mem_wr_req), .mem_wr_addr(fp_mem_wr_addr),
    .mem_wr_line(fp_mem_wr_line), .mem_wr_data(fp_mem_wr_data),
    .mem_wr_strb(fp_mem_wr_strb), .mem_wr_rdy(mem_wr_rdy), .mem_bvalid(mem_bvalid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ic_rd_req = 0; dc_rd_req = 0; dc_wr_req = 0; uc_ren = 0; uc_wen = 0;
    ic_rd_addr = 0; dc_rd_addr = 0; dc_wr_addr = 0; uc_araddr = 0; uc_awaddr = 0;
    uc_wdata = 0; uc_wstrb = 0; dc_wr_data = 0; mem_ret_data = 0;
    mem_rd_rdy = 0; mem_ret_valid = 0; mem_wr_rdy = 0; mem_bvalid = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    ic_rd_req = 1; dc_wr_req = 1;
    #1;
    vectors++;
    if ({ic_rd_rdy, dc_wr_rdy} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_rdy: got %b want 00", {ic_rd_rdy, dc_wr_rdy});
    end
    tick();
    vectors++;
    if ({mem_rd_req, mem_wr_req, ic_ret_valid, dc_bvalid, uc_rvalid} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outs: got %b want 00000",
               {mem_rd_req, mem_wr_req, ic_ret_valid, dc_bvalid, uc_rvalid});
    end
    vectors++;
    if ({mem_rd_addr, mem_wr_strb} !== 36'h0) begin
      miscompares++;
      $display("FAIL reset_fields: got %h want 0", {mem_rd_addr, mem_wr_strb});
    end
    clear_inputs();
    reset = 0;
    tick();
  endtask

  task automatic test_ic_refill();
    do_reset();
    ic_rd_req = 1; ic_rd_addr = 32'h0000_1234;
    #1;
    vectors++;
    if (ic_rd_rdy !== 1'b1) begin
      miscompares++; $display("FAIL ic_rdy: got %b want 1", ic_rd_rdy);
    end
    tick();
    ic_rd_req = 0;
    vectors++;
    if ({mem_rd_req, mem_rd_line, mem_rd_addr} !== {2'b11, 32'h0000_1220}) begin
      miscompares++;
      $display("FAIL ic_issue: got req=%b line=%b addr=%h want 1 1 00001220",
               mem_rd_req, mem_rd_line, mem_rd_addr);
    end
    mem_rd_rdy = 1;
    tick();
    mem_rd_rdy = 0;
    mem_ret_valid = 1; mem_ret_data = LineA;
    tick();
    mem_ret_valid = 0; mem_ret_data = 0;
    vectors++;
    if ({ic_ret_valid, ic_ret_data} !== {1'b1, LineA}) begin
      miscompares++;
      $display("FAIL ic_ret: got v=%b d=%h want 1 %h", ic_ret_valid, ic_ret_data, LineA);
    end
    vectors++;
    if ({dc_ret_valid, dc_ret_data, dc_bvalid} !== '0) begin
      miscompares++; $display("FAIL ic_dc_quiet: got dc_ret_valid=%b want 0", dc_ret_valid);
    end
    tick();
    vectors++;
    if ({ic_ret_valid, ic_ret_data} !== '0) begin
      miscompares++; $display("FAIL ic_pulse_end: got v=%b want 0 with zero data", ic_ret_valid);
    end
  endtask

  task automatic test_wb_before_refill();
    do_reset();
    dc_wr_req = 1; dc_wr_addr = 32'h40; dc_wr_data = LineW;
    dc_rd_req = 1; dc_rd_addr = 32'h80;
    #1;
    vectors++;
    if ({dc_wr_rdy, dc_rd_rdy} !== 2'b10) begin
      miscompares++; $display("FAIL wb_first: got %b want 10", {dc_wr_rdy, dc_rd_rdy});
    end
    tick();
    dc_wr_req = 0;
    vectors++;
    if ({mem_wr_req, mem_wr_line, mem_wr_strb, mem_wr_addr, mem_wr_data}
        !== {2'b11, 4'hF, 32'h40, LineW}) begin
      miscompares++;
      $display("FAIL wb_issue: got req=%b line=%b strb=%h addr=%h want 1 1 f 00000040",
               mem_wr_req, mem_wr_line, mem_wr_strb, mem_wr_addr);
    end
    mem_wr_rdy = 1;
    tick();
    mem_wr_rdy = 0;
    vectors++;
    if ({dc_rd_rdy, mem_rd_req} !== 2'b00) begin
      miscompares++; $display("FAIL wb_wait_block: got %b want 00", {dc_rd_rdy, mem_rd_req});
    end
    mem_bvalid = 1;
    tick();
    mem_bvalid = 0;
    vectors++;
    if ({dc_bvalid, dc_rd_rdy} !== 2'b10) begin
      miscompares++; $display("FAIL wb_bvalid: got %b want 10", {dc_bvalid, dc_rd_rdy});
    end
    tick();
    vectors++;
    if ({dc_bvalid, dc_rd_rdy} !== 2'b01) begin
      miscompares++; $display("FAIL wb_then_rd: got %b want 01", {dc_bvalid, dc_rd_rdy});
    end
    tick();
    dc_rd_req = 0;
    vectors++;
    if ({mem_rd_req, mem_rd_addr} !== {1'b1, 32'h80}) begin
      miscompares++;
      $display("FAIL rd_after_wb: got req=%b addr=%h want 1 00000080", mem_rd_req, mem_rd_addr);
    end
  endtask

  task automatic test_round_robin();
    int n;
    logic got_dc;
    do_reset();
    mem_rd_rdy = 1; mem_ret_valid = 1; mem_ret_data = LineA;
    ic_rd_req = 1; ic_rd_addr = 32'h100;
    dc_rd_req = 1; dc_rd_addr = 32'h200;
    #1;
    for (int r = 0; r < 4; r++) begin
      n = 0;
      while (!(ic_rd_rdy || dc_rd_rdy) && n < 10) begin
        tick();
        n++;
      end
      vectors++;
      got_dc = dc_rd_rdy;
      if (n >= 10) begin
        miscompares++; $display("FAIL rr_timeout: round %0d got no grant want grant", r);
      end else if ({ic_rd_rdy, dc_rd_rdy} !== ((r % 2 == 0) ? 2'b10 : 2'b01)) begin
        miscompares++;
        $display("FAIL rr_order: round %0d got ic=%b dc=%b want %s", r, ic_rd_rdy, got_dc,
                 (r % 2 == 0) ? "ic" : "dc");
      end
      vectors++;
      if ({fp_ic_rd_rdy, fp_dc_rd_rdy} !== 2'b01) begin
        miscompares++;
        $display("FAIL fixed_dc_first: round %0d got ic=%b dc=%b want ic=0 dc=1", r,
                 fp_ic_rd_rdy, fp_dc_rd_rdy);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_uncached();
    do_reset();
    uc_ren = 1; uc_araddr = 32'h0000_0010;
    #1;
    vectors++;
    if (uc_rrdy !== 1'b1) begin
      miscompares++; $display("FAIL uc_rrdy: got %b want 1", uc_rrdy);
    end
    tick();
    uc_ren = 0;
    vectors++;
    if ({mem_rd_req, mem_rd_line, mem_rd_addr} !== {2'b10, 32'h10}) begin
      miscompares++;
      $display("FAIL uc_rd_issue: got req=%b line=%b addr=%h want 1 0 00000010",
               mem_rd_req, mem_rd_line, mem_rd_addr);
    end
    mem_rd_rdy = 1;
    tick();
    mem_rd_rdy = 0;
    mem_ret_valid = 1; mem_ret_data = LineU;
    tick();
    mem_ret_valid = 0; mem_ret_data = 0;
    vectors++;
    if ({uc_rvalid, uc_rdata, ic_ret_valid, dc_ret_valid} !== {1'b1, 32'hDEAD_BEEF, 2'b00}) begin
      miscompares++;
      $display("FAIL uc_rdata: got v=%b d=%h want 1 deadbeef", uc_rvalid, uc_rdata);
    end
    tick();
    vectors++;
    if ({uc_rvalid, uc_rdata} !== 33'h0) begin
      miscompares++; $display("FAIL uc_rdata_zero: got %h want 0", uc_rdata);
    end
    uc_wen = 1; uc_awaddr = 32'h0000_0104; uc_wdata = 32'h1234_5678; uc_wstrb = 4'b0011;
    #1;
    vectors++;
    if (uc_wrdy !== 1'b1) begin
      miscompares++; $display("FAIL uc_wrdy: got %b want 1", uc_wrdy);
    end
    tick();
    uc_wen = 0;
    vectors++;
    if ({mem_wr_req, mem_wr_line, mem_wr_strb, mem_wr_addr, mem_wr_data[31:0]}
        !== {2'b10, 4'b0011, 32'h104, 32'h1234_5678}) begin
      miscompares++;
      $display("FAIL uc_wr_issue: got req=%b line=%b strb=%b addr=%h d=%h want 1 0 0011 104",
               mem_wr_req, mem_wr_line, mem_wr_strb, mem_wr_addr, mem_wr_data[31:0]);
    end
    mem_wr_rdy = 1;
    tick();
    mem_wr_rdy = 0;
    mem_bvalid = 1;
    tick();
    mem_bvalid = 0;
    vectors++;
    if ({uc_bvalid, dc_bvalid} !== 2'b10) begin
      miscompares++; $display("FAIL uc_bvalid: got %b want 10", {uc_bvalid, dc_bvalid});
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ic_rd_req = 1; ic_rd_addr = 32'h0000_2000;
    tick();
    ic_rd_req = 0;
    dc_rd_req = 1; dc_rd_addr = 32'h0000_3000;
    for (int c = 0; c < 5; c++) begin
      mem_ret_valid = (c == 2);
      #1;
      vectors++;
      if ({mem_rd_req, mem_rd_addr, mem_rd_line, dc_rd_rdy} !== {1'b1, 32'h2000, 2'b10}) begin
        miscompares++;
        $display("FAIL stall_hold: cycle %0d got req=%b addr=%h rdy=%b want 1 00002000 0",
                 c, mem_rd_req, mem_rd_addr, dc_rd_rdy);
      end
      tick();
    end
    mem_ret_valid = 0;
    mem_rd_rdy = 1;
    tick();
    mem_rd_rdy = 0;
    mem_ret_valid = 1; mem_ret_data = LineW;
    tick();
    mem_ret_valid = 0;
    vectors++;
    if ({ic_ret_valid, dc_ret_valid, ic_ret_data} !== {2'b10, LineW}) begin
      miscompares++;
      $display("FAIL stall_ret: got ic=%b dc=%b want 1 0", ic_ret_valid, dc_ret_valid);
    end
    tick();
    vectors++;
    if (dc_rd_rdy !== 1'b1) begin
      miscompares++; $display("FAIL stall_next_grant: got %b want 1", dc_rd_rdy);
    end
    dc_rd_req = 0;
  endtask

  task automatic test_reset_abort();
    do_reset();
    ic_rd_req = 1; ic_rd_addr = 32'h0000_3000;
    tick();
    ic_rd_req = 0;
    mem_rd_rdy = 1;
    tick();
    mem_rd_rdy = 0;
    reset = 1;
    tick();
    reset = 0;
    mem_ret_valid = 1; mem_ret_data = LineA;
    #1;
    vectors++;
    if ({mem_rd_req, mem_wr_req} !== 2'b00) begin
      miscompares++; $display("FAIL abort_idle: got %b want 00", {mem_rd_req, mem_wr_req});
    end
    tick();
    mem_ret_valid = 0; mem_ret_data = 0;
    vectors++;
    if ({ic_ret_valid, dc_ret_valid, ic_ret_data} !== '0) begin
      miscompares++;
      $display("FAIL abort_no_pulse: got ic=%b dc=%b want 0 0", ic_ret_valid, dc_ret_valid);
    end
    ic_rd_req = 1; ic_rd_addr = 32'h0000_3047;
    #1;
    vectors++;
    if (ic_rd_rdy !== 1'b1) begin
      miscompares++; $display("FAIL abort_next_rdy: got %b want 1", ic_rd_rdy);
    end
    tick();
    ic_rd_req = 0;
    vectors++;
    if ({mem_rd_req, mem_rd_addr} !== {1'b1, 32'h0000_3040}) begin
      miscompares++;
      $display("FAIL abort_next_addr: got req=%b addr=%h want 1 00003040",
               mem_rd_req, mem_rd_addr);
    end
    mem_rd_rdy = 1;
    mem_ret_valid = 1; mem_ret_data = LineW;
    tick();
    mem_rd_rdy = 0;
    tick();
    mem_ret_valid = 0;
    vectors++;
    if ({ic_ret_valid, ic_ret_data} !== {1'b1, LineW}) begin
      miscompares++; $display("FAIL abort_next_ret: got v=%b want 1", ic_ret_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ic_refill();
    test_wb_before_refill();
    test_round_robin();
    test_uncached();
    test_backpressure();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
